// File: rtl/bcd_stopwatch_ctrl_if.sv
// Control and status bundle between button conditioning and the BCD stopwatch core.
// The master drives the button pulses; the slave (the core) returns count and status.
interface bcd_stopwatch_ctrl_if #(
  parameter int MIN_DIGITS = 2
);
  localparam int W = 4 * (2 + MIN_DIGITS);

  logic         CLEAR;
  logic         START;
  logic         REVERSE;
  logic [W-1:0] LIMIT;
  logic         SPEED_UP;
  logic         SPEED_DOWN;
  logic         ADD;
  logic         SUBTRACT;
  logic         LAP;
  logic [W-1:0] Q;
  logic [W-1:0] LAP_Q;
  logic         LAP_VALID;
  logic         RUNNING;
  logic         DONE;
  logic [1:0]   SPEED;

  modport master (
    output CLEAR, START, REVERSE, LIMIT, SPEED_UP, SPEED_DOWN, ADD, SUBTRACT, LAP,
    input  Q, LAP_Q, LAP_VALID, RUNNING, DONE, SPEED
  );

  modport slave (
    input  CLEAR, START, REVERSE, LIMIT, SPEED_UP, SPEED_DOWN, ADD, SUBTRACT, LAP,
    output Q, LAP_Q, LAP_VALID, RUNNING, DONE, SPEED
  );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// BCD stopwatch / countdown core: MM..:SS counter with run/pause/done control,
// four-step tick prescaler, saturating minute adjust and lap capture.
module bcd_stopwatch_ctrl #(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 50_000_000
) (
  input  logic                 clk,
  input  logic                 RESET_N,
  bcd_stopwatch_ctrl_if.slave  bus
);
  localparam int          W    = 4 * (2 + MIN_DIGITS);
  localparam int unsigned NDIG = 2 + MIN_DIGITS;
  localparam int          PW   = $clog2(TICK_DIV);

  // Encoded so RUNNING and DONE are plain state register bits.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_RUN   = 3'b001,
    ST_DONE  = 3'b010,
    ST_PAUSE = 3'b100
  } state_t;

  state_t        state;
  logic [W-1:0]  q_r;
  logic [W-1:0]  lap_q_r;
  logic [W-1:0]  limit_r;
  logic          lap_valid_r;
  logic          dir_r;
  logic [1:0]    speed_r;
  logic [PW-1:0] presc_r;

  // Ripple one BCD step starting at digit 'first'; MSB of result is carry/borrow out.
  function automatic logic [W:0] bcd_step(input logic [W-1:0] v, input int unsigned first,
                                          input logic down);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   top;
    logic [3:0]   d;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (c && i >= first) begin
        top = (i == 1) ? 4'd5 : 4'd9;
        d   = r[4*i +: 4];
        if (down) begin
          if (d == 4'd0) d = top;
          else begin d = d - 4'd1; c = 1'b0; end
        end else begin
          if (d == top) d = 4'd0;
          else begin d = d + 4'd1; c = 1'b0; end
        end
        r[4*i +: 4] = d;
      end
    end
    return {c, r};
  endfunction

  logic [PW-1:0] period_m1;
  logic          speed_inc, speed_dec, speed_chg;
  logic          tick, tick_hit, adj_req, adj_hit;
  logic [W:0]    tick_nx, add_nx, sub_nx;
  logic [W-1:0]  term_val, adj_val;

  always_comb begin
    period_m1 = PW'((32'(TICK_DIV) >> speed_r) - 32'd1);
    speed_inc = bus.SPEED_UP && !bus.SPEED_DOWN && (speed_r != 2'd3);
    speed_dec = bus.SPEED_DOWN && !bus.SPEED_UP && (speed_r != 2'd0);
    speed_chg = speed_inc || speed_dec;
    tick      = (state == ST_RUN) && (presc_r == period_m1);
    term_val  = dir_r ? '0 : limit_r;
    tick_nx   = bcd_step(q_r, 0, dir_r);
    // A ripple out of the top digit can only follow the terminal value, so treat it as terminal.
    tick_hit  = tick_nx[W] || (tick_nx[W-1:0] == term_val);
    add_nx    = bcd_step(q_r, 2, 1'b0);
    sub_nx    = bcd_step(q_r, 2, 1'b1);
    adj_req   = (bus.ADD ^ bus.SUBTRACT) && (state != ST_DONE);
    if (bus.ADD)
      adj_val = (add_nx[W] || (add_nx[W-1:0] > limit_r)) ? limit_r : add_nx[W-1:0];
    else
      adj_val = sub_nx[W] ? '0 : sub_nx[W-1:0];
    adj_hit   = (bus.ADD && !dir_r && (adj_val == limit_r)) ||
                (bus.SUBTRACT && dir_r && (adj_val == '0));
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      q_r         <= '0;
      lap_q_r     <= '0;
      limit_r     <= '0;
      lap_valid_r <= 1'b0;
      dir_r       <= 1'b0;
      speed_r     <= '0;
      presc_r     <= '0;
    end else begin
      if (speed_inc)      speed_r <= speed_r + 2'd1;
      else if (speed_dec) speed_r <= speed_r - 2'd1;

      if (bus.CLEAR) begin
        limit_r     <= bus.LIMIT;
        dir_r       <= bus.REVERSE;
        q_r         <= bus.REVERSE ? bus.LIMIT : '0;
        presc_r     <= '0;
        lap_valid_r <= 1'b0;
        lap_q_r     <= '0;
        state       <= ST_IDLE;
      end else begin
        if (bus.LAP && (state == ST_RUN || state == ST_PAUSE)) begin
          lap_q_r     <= q_r;
          lap_valid_r <= 1'b1;
        end

        if (state == ST_RUN)
          presc_r <= (speed_chg || tick) ? '0 : presc_r + PW'(1);
        else if (speed_chg)
          presc_r <= '0;

        if (bus.START && state != ST_DONE) begin
          if (state == ST_RUN) begin
            state <= ST_PAUSE;
          end else begin
            presc_r <= '0;
            state   <= (q_r == term_val) ? ST_DONE : ST_RUN;
          end
        end else if (adj_req) begin
          q_r <= adj_val;
          if (state == ST_RUN && adj_hit) state <= ST_DONE;
        end else if (tick) begin
          q_r <= tick_hit ? term_val : tick_nx[W-1:0];
          if (tick_hit) state <= ST_DONE;
        end
      end
    end
  end

  assign bus.Q         = q_r;
  assign bus.LAP_Q     = lap_q_r;
  assign bus.LAP_VALID = lap_valid_r;
  assign bus.RUNNING   = state[0];
  assign bus.DONE      = state[1];
  assign bus.SPEED     = speed_r;
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl (MIN_DIGITS=2, TICK_DIV=8) with an expected-value queue.
module tb_bcd_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] prev_q = '0;
  logic        mon_en = 1'b0;

  typedef enum {P_CLEAR, P_START, P_UP, P_DOWN, P_ADD, P_SUB, P_LAP} pulse_t;

  bcd_stopwatch_ctrl_if #(.MIN_DIGITS(2)) bus ();

  bcd_stopwatch_ctrl #(.MIN_DIGITS(2), .TICK_DIV(8)) dut (
    .clk     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the next expected value; an empty queue yields a value no 16-bit output can match.
  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    if (exp_q.size() == 0) exp = 32'hDEAD_BEEF;
    else exp = {16'h0, exp_q.pop_front()};
    chk(tag, obs, exp);
  endtask

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic drop_pulses();
    bus.CLEAR = 0; bus.START = 0; bus.SPEED_UP = 0; bus.SPEED_DOWN = 0;
    bus.ADD = 0; bus.SUBTRACT = 0; bus.LAP = 0;
  endtask

  task automatic pulse(input pulse_t p);
    case (p)
      P_CLEAR: bus.CLEAR      = 1;
      P_START: bus.START      = 1;
      P_UP:    bus.SPEED_UP   = 1;
      P_DOWN:  bus.SPEED_DOWN = 1;
      P_ADD:   bus.ADD        = 1;
      P_SUB:   bus.SUBTRACT   = 1;
      P_LAP:   bus.LAP        = 1;
      default: ;
    endcase
    cyc(1);
    drop_pulses();
  endtask

  task automatic do_clear(input logic rev, input logic [15:0] lim);
    bus.REVERSE = rev;
    bus.LIMIT   = lim;
    pulse(P_CLEAR);
  endtask

  always @(negedge clk) begin
    if (mon_en && bus.Q !== prev_q) sb_check("seq", {16'h0, bus.Q});
    prev_q = bus.Q;
  end

  initial begin
    rst_n = 1'b0;
    bus.REVERSE = 0;
    bus.LIMIT = '0;
    drop_pulses();
    cyc(2);
    chk("rst_q", bus.Q, 0);
    chk("rst_lap_q", bus.LAP_Q, 0);
    chk("rst_lap_valid", bus.LAP_VALID, 0);
    chk("rst_speed", bus.SPEED, 0);
    chk("rst_running", bus.RUNNING, 0);
    chk("rst_done", bus.DONE, 0);
    rst_n = 1'b1;
    cyc(1);

    // Count up to 10:00 at speed 0, every second checked in order.
    do_clear(1'b0, 16'h1000);
    for (int s = 1; s <= 600; s++) exp_q.push_back(to_bcd(s));
    prev_q = bus.Q;
    mon_en = 1;
    pulse(P_START);
    cyc(480);
    chk("up_1min_q", bus.Q, 16'h0100);
    chk("up_running", bus.RUNNING, 1);
    cyc(4319);
    chk("up_0959_q", bus.Q, 16'h0959);
    chk("up_0959_done", bus.DONE, 0);
    cyc(1);
    chk("up_limit_q", bus.Q, 16'h1000);
    chk("up_done", bus.DONE, 1);
    chk("up_done_running", bus.RUNNING, 0);
    pulse(P_START);
    cyc(100);
    chk("done_hold_q", bus.Q, 16'h1000);
    chk("done_start_ignored", bus.DONE, 1);
    chk("up_sb_drained", exp_q.size(), 0);
    mon_en = 0;

    // Countdown from 00:30 at speed 3 (one tick per cycle).
    do_clear(1'b1, 16'h0030);
    chk("down_load_q", bus.Q, 16'h0030);
    chk("clear_keeps_done_off", bus.DONE, 0);
    repeat (4) pulse(P_UP);
    chk("speed_sat_hi", bus.SPEED, 3);
    bus.SPEED_DOWN = 1;
    pulse(P_UP);
    chk("speed_both", bus.SPEED, 3);
    for (int s = 29; s >= 0; s--) exp_q.push_back(to_bcd(s));
    prev_q = bus.Q;
    mon_en = 1;
    pulse(P_START);
    cyc(30);
    chk("down_zero_q", bus.Q, 0);
    chk("down_done", bus.DONE, 1);
    cyc(2);
    chk("down_sb_drained", exp_q.size(), 0);
    mon_en = 0;

    // Minute adjust and saturation, limit 05:00.
    do_clear(1'b0, 16'h0500);
    repeat (4) pulse(P_ADD);
    chk("idle_add_q", bus.Q, 16'h0400);
    pulse(P_START);
    cyc(45);
    chk("run_0445_q", bus.Q, 16'h0445);
    pulse(P_START);
    chk("pause_running", bus.RUNNING, 0);
    chk("pause_q", bus.Q, 16'h0445);
    pulse(P_ADD);
    chk("add_sat_q", bus.Q, 16'h0500);
    chk("add_sat_no_done", bus.DONE, 0);
    exp_q.push_back(16'h0400); exp_q.push_back(16'h0300); exp_q.push_back(16'h0200);
    exp_q.push_back(16'h0100); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    repeat (6) begin
      pulse(P_SUB);
      sb_check("sub_step", {16'h0, bus.Q});
    end
    bus.ADD = 1;
    pulse(P_SUB);
    chk("add_sub_both", bus.Q, 0);
    repeat (3) pulse(P_DOWN);
    chk("speed_sat_lo", bus.SPEED, 0);
    pulse(P_START);
    bus.ADD = 1;
    cyc(5);
    drop_pulses();
    chk("run_add_limit_q", bus.Q, 16'h0500);
    chk("run_add_limit_done", bus.DONE, 1);

    // Lap captured on the same edge as a tick.
    do_clear(1'b0, 16'h1000);
    pulse(P_LAP);
    chk("lap_idle_ignored", bus.LAP_VALID, 0);
    repeat (3) pulse(P_UP);
    pulse(P_START);
    cyc(83);
    chk("lap_pre_q", bus.Q, 16'h0123);
    exp_q.push_back(16'h0123);
    pulse(P_LAP);
    sb_check("lap_q", {16'h0, bus.LAP_Q});
    chk("lap_tick_q", bus.Q, 16'h0124);
    chk("lap_valid", bus.LAP_VALID, 1);
    pulse(P_CLEAR);
    chk("clr_lap_valid", bus.LAP_VALID, 0);
    chk("clr_lap_q", bus.LAP_Q, 0);
    chk("clr_running", bus.RUNNING, 0);

    // Asynchronous reset mid-run.
    pulse(P_START);
    cyc(5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", bus.Q, 0);
    chk("async_rst_speed", bus.SPEED, 0);
    chk("async_rst_running", bus.RUNNING, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    pulse(P_START);
    chk("start_at_terminal_done", bus.DONE, 1);
    bus.LIMIT = 16'h0100;
    bus.REVERSE = 0;
    bus.START = 1;
    pulse(P_CLEAR);
    chk("clear_start_done", bus.DONE, 0);
    chk("clear_start_running", bus.RUNNING, 0);
    cyc(20);
    chk("clear_start_q", bus.Q, 0);
    chk("clear_start_idle", bus.RUNNING, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
